// File: rtl/serializer_pkg.sv
// Shared types and defaults for the byte serializer and its bit timer.
package serializer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } ser_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BIT_CYCLES = 1;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Modulo-BIT_CYCLES counter; o_tick marks the last cycle of each bit period.
module bit_tick_gen
  import serializer_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW   = min1_clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count while enabled, wrap at the bit period, hold at zero while cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/byte_serializer.sv
// Pulls one word from the queue and shifts it out MSB first, one write strobe per bit.
module byte_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH    = 4,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  dequeue_out,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  status_out,
  output logic                  done_out
);

  localparam int             BCW       = min1_clog2(DATA_WIDTH);
  localparam int             LCW       = min1_clog2(READ_LATENCY);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_WIDTH - 1);
  localparam logic [LCW-1:0] LAST_LOAD = LCW'(READ_LATENCY - 1);

  ser_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BCW-1:0]        r_bit_cnt;
  logic [LCW-1:0]        r_load_cnt;
  logic                  r_dequeue;
  logic                  r_data;
  logic                  r_write;
  logic                  r_status;
  logic                  r_done;

  logic w_tick;
  logic w_timer_en;
  logic w_timer_clr;

  // The bit timer only runs in SHIFT, so it always starts a word at zero.
  assign w_timer_en  = (r_state == SHIFT);
  assign w_timer_clr = (r_state != SHIFT);

  bit_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .i_clk  (clock),
    .i_rst_n(reset),
    .i_clr  (w_timer_clr),
    .i_en   (w_timer_en),
    .o_tick (w_tick)
  );

  // FSM with shift register, bit counter and outputs registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_load_cnt <= '0;
      r_dequeue  <= 1'b0;
      r_data     <= 1'b0;
      r_write    <= 1'b0;
      r_status   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_dequeue <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable_in && (len_in != '0)) begin
            r_state   <= REQ;
            r_dequeue <= 1'b1;
            r_status  <= 1'b1;
          end
        end
        REQ: begin
          r_state    <= LOAD;
          r_load_cnt <= '0;
        end
        LOAD: begin
          if (r_load_cnt == LAST_LOAD) begin
            r_state   <= SHIFT;
            r_shift   <= data_in;
            r_bit_cnt <= '0;
            r_data    <= data_in[DATA_WIDTH-1];
            r_write   <= 1'b1;
          end else begin
            r_load_cnt <= r_load_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
              r_state   <= GAP;
              r_bit_cnt <= '0;
              r_data    <= 1'b0;
              r_write   <= 1'b0;
              r_status  <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_shift   <= r_shift << 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_data    <= r_shift[DATA_WIDTH-2];
            end
          end
        end
        GAP: begin
          // One idle-bound cycle so len_in reflects the dequeue before it is sampled again.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dequeue_out = r_dequeue;
  assign data_out    = r_data;
  assign write_out   = r_write;
  assign status_out  = r_status;
  assign done_out    = r_done;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: a queue model feeds the DUT and each output trace is
// compared cycle by cycle against a trace built from the word list.
module tb_byte_serializer;

  localparam int W    = 8;
  localparam int MAXC = 120;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       sel;
  logic [3:0] len_in;
  logic [7:0] data_in;

  logic en1, en4;
  logic d1_deq, d1_dat, d1_wr, d1_stat, d1_done;
  logic d4_deq, d4_dat, d4_wr, d4_stat, d4_done;
  logic [4:0] v1, v4, vsel;

  always #5 clock = ~clock;

  assign en1  = enable & ~sel;
  assign en4  = enable & sel;
  assign v1   = {d1_deq, d1_wr, d1_dat, d1_stat, d1_done};
  assign v4   = {d4_deq, d4_wr, d4_dat, d4_stat, d4_done};
  assign vsel = sel ? v4 : v1;

  byte_serializer #(
    .DATA_WIDTH(8), .LEN_WIDTH(4), .BIT_CYCLES(1), .READ_LATENCY(1)
  ) dut1 (
    .clock(clock), .reset(reset), .enable_in(en1), .len_in(len_in), .data_in(data_in),
    .dequeue_out(d1_deq), .data_out(d1_dat), .write_out(d1_wr),
    .status_out(d1_stat), .done_out(d1_done)
  );

  byte_serializer #(
    .DATA_WIDTH(8), .LEN_WIDTH(4), .BIT_CYCLES(4), .READ_LATENCY(1)
  ) dut4 (
    .clock(clock), .reset(reset), .enable_in(en4), .len_in(len_in), .data_in(data_in),
    .dequeue_out(d4_deq), .data_out(d4_dat), .write_out(d4_wr),
    .status_out(d4_stat), .done_out(d4_done)
  );

  int total = 0;
  int bad   = 0;

  // Trace vectors are {dequeue, write, data, status, done}.
  logic [4:0] obs   [0:MAXC];
  logic [4:0] exp_v [0:MAXC];
  int         cyc;
  logic [7:0] q[$];
  logic [7:0] pend;
  bit         pend_v;
  bit         show;

  task automatic clear_exp();
    for (int i = 0; i <= MAXC; i++) begin
      exp_v[i] = '0;
      obs[i]   = '0;
    end
    cyc = 0;
  endtask

  // Expected trace of one word whose start condition is sampled at edge s.
  task automatic add_word(input int s, input logic [7:0] b, input int bc);
    exp_v[s+1] = 5'b10010;
    exp_v[s+2] = 5'b00010;
    for (int k = 0; k < W*bc; k++)
      exp_v[s+3+k] = {1'b0, 1'b1, b[W-1-k/bc], 1'b1, 1'b0};
    exp_v[s+3+W*bc] = 5'b00001;
  endtask

  // Advance n cycles, recording outputs mid-cycle; data_in is valid only in the
  // cycle after a dequeue and is random otherwise.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cyc++;
      obs[cyc] = vsel;
      if (show) begin
        data_in = 8'($urandom);
        show    = 1'b0;
      end
      if (pend_v) begin
        data_in = pend;
        pend_v  = 1'b0;
        show    = 1'b1;
      end
      if (vsel[4]) begin
        if (q.size() > 0) pend = q.pop_front();
        else              pend = 8'($urandom);
        pend_v = 1'b1;
      end
      len_in = 4'(q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (v1 !== 5'b0) begin bad++; $display("FAIL reset_dut1 got=%b exp=%b", v1, 5'b0); end
    total++;
    if (v4 !== 5'b0) begin bad++; $display("FAIL reset_dut4 got=%b exp=%b", v4, 5'b0); end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({v1, v4} !== 10'b0) begin bad++; $display("FAIL post_reset got=%b exp=%b", {v1, v4}, 10'b0); end
  endtask

  task automatic test_single();
    sel = 1'b0;
    q   = '{8'hA5};
    clear_exp();
    @(negedge clock);
    len_in = 4'(q.size());
    enable = 1'b1;
    add_word(0, 8'hA5, 1);
    run_cycles(14);
    enable = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL single cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_empty();
    sel = 1'b0;
    q.delete();
    clear_exp();
    @(negedge clock);
    len_in = 4'd0;
    enable = 1'b1;
    run_cycles(50);
    enable = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      total++;
      if (obs[c] !== 5'b0) begin
        bad++;
        $display("FAIL empty cyc=%0d got=%b exp=%b", c, obs[c], 5'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int ndeq;
    sel = 1'b0;
    q   = '{8'h3C, 8'hFF};
    clear_exp();
    @(negedge clock);
    len_in = 4'(q.size());
    enable = 1'b1;
    add_word(0, 8'h3C, 1);
    add_word(12, 8'hFF, 1);
    run_cycles(30);
    enable = 1'b0;
    ndone = 0;
    ndeq  = 0;
    for (int c = 1; c <= 30; c++) begin
      ndone += int'(obs[c][0]);
      ndeq  += int'(obs[c][4]);
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
    total++;
    if (ndone != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=%0d", ndone, 2); end
    total++;
    if (ndeq != 2) begin bad++; $display("FAIL b2b_deq_count got=%0d exp=%0d", ndeq, 2); end
  endtask

  task automatic test_bit_cycles4();
    sel = 1'b1;
    q   = '{8'h81};
    clear_exp();
    @(negedge clock);
    len_in = 4'(q.size());
    enable = 1'b1;
    add_word(0, 8'h81, 4);
    run_cycles(37);
    enable = 1'b0;
    for (int c = 1; c <= 37; c++) begin
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL bc4 cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
    @(negedge clock);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] w2;
    w2  = 8'($urandom);
    sel = 1'b0;
    q   = '{8'hF0, w2};
    clear_exp();
    @(negedge clock);
    len_in = 4'(q.size());
    enable = 1'b1;
    add_word(0, 8'hF0, 1);
    run_cycles(6);
    for (int c = 1; c <= 6; c++) begin
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (v1 !== 5'b0) begin bad++; $display("FAIL async_reset got=%b exp=%b", v1, 5'b0); end
    @(posedge clock);
    #1;
    total++;
    if (v1 !== 5'b0) begin bad++; $display("FAIL held_reset got=%b exp=%b", v1, 5'b0); end
    @(negedge clock);
    pend_v  = 1'b0;
    show    = 1'b0;
    data_in = 8'($urandom);
    clear_exp();
    len_in = 4'(q.size());
    reset  = 1'b1;
    add_word(0, w2, 1);
    run_cycles(14);
    enable = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL after_reset cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL after_reset_qsize got=%0d exp=%0d", q.size(), 0); end
  endtask

  task automatic test_enable_drop();
    logic [7:0] w0;
    w0  = 8'($urandom);
    sel = 1'b0;
    q   = '{w0, 8'($urandom), 8'($urandom), 8'($urandom)};
    clear_exp();
    @(negedge clock);
    len_in = 4'(q.size());
    enable = 1'b1;
    add_word(0, w0, 1);
    run_cycles(5);
    enable = 1'b0;
    run_cycles(25);
    for (int c = 1; c <= 30; c++) begin
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL en_drop cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
    total++;
    if (q.size() != 3) begin bad++; $display("FAIL en_drop_qsize got=%0d exp=%0d", q.size(), 3); end
    q.delete();
    @(negedge clock);
    len_in = 4'd0;
  endtask

  task automatic test_random();
    logic [7:0] w[3];
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    sel = 1'b0;
    q   = '{w[0], w[1], w[2]};
    clear_exp();
    @(negedge clock);
    len_in = 4'(q.size());
    enable = 1'b1;
    for (int i = 0; i < 3; i++) add_word(12*i, w[i], 1);
    run_cycles(40);
    enable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      total++;
      if (obs[c] !== exp_v[c]) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", c, obs[c], exp_v[c]);
      end
    end
  endtask

  initial begin
    reset   = 1'b0;
    enable  = 1'b0;
    sel     = 1'b0;
    len_in  = 4'd0;
    data_in = 8'($urandom);
    pend    = 8'd0;
    pend_v  = 1'b0;
    show    = 1'b0;
    cyc     = 0;
    test_reset();
    test_single();
    test_empty();
    test_back_to_back();
    test_bit_cycles4();
    test_reset_mid_shift();
    test_enable_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Transmit-side counterpart of the deserializer. It pulls bytes from the queue through the queue's dequeue/len/data interface and shifts each byte out serially, MSB first. Each bit is qualified by a write strobe so a deserializer on the far end can reassemble the byte. It sits after the queue in the datapath and runs on a single clock.

Parameters:
DATA_WIDTH, 8, bits per word; the width of data_in and the shift register.
LEN_WIDTH, 4, width of the queue occupancy input.
BIT_CYCLES, 1, clock cycles each serial bit is held (>=1).
READ_LATENCY, 1, cycles from dequeue_out to valid data_in (>=1).

Ports:
clock  in  1  single system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
enable_in  in  1  permits starting a new word; sampled only in IDLE.
len_in  in  LEN_WIDTH  queue occupancy; a nonzero value means a word is available.
data_in  in  DATA_WIDTH  queue read data; valid READ_LATENCY cycles after dequeue_out.
dequeue_out  out  1  one-cycle dequeue request to the queue.
data_out  out  1  serial bit, MSB first.
write_out  out  1  high while data_out carries a valid bit.
status_out  out  1  high from REQ through the end of SHIFT (word in flight).
done_out  out  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0.
  - State returns to IDLE; the shift register and counters clear.
  - A word that was already dequeued is discarded; no retry.
- All outputs are registered.
- States: IDLE, REQ, LOAD, SHIFT, GAP.
- IDLE:
  - If enable_in=1 and len_in!=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ (1 cycle):
  - dequeue_out=1, status_out=1.
  - Next state is LOAD.
- LOAD (READ_LATENCY cycles):
  - status_out=1.
  - On the last LOAD cycle's edge, capture data_in into the shift register and enter SHIFT.
- SHIFT (DATA_WIDTH*BIT_CYCLES cycles):
  - data_out = shift register MSB; write_out=1; status_out=1.
  - The bit timer counts 0..BIT_CYCLES-1.
  - On timer wrap, shift left by 1 and increment the bit counter.
  - After bit DATA_WIDTH-1 completes, go to GAP.
- GAP (1 cycle):
  - done_out=1; write_out=0; status_out=0; data_out=0.
  - Next state is IDLE. This cycle guarantees len_in has already reflected the dequeue before it is re-sampled.
- Latency (BIT_CYCLES=1, READ_LATENCY=1):
  - Start condition seen at edge 0.
  - REQ in cycle 1, LOAD in cycle 2, bits in cycles 3..10, GAP in cycle 11, IDLE in cycle 12.
  - Back-to-back words therefore run 12 cycles apart.
- enable_in deasserted mid-word: the word completes; no new word starts until enable_in=1 again.
- len_in changing during a word is ignored; it is sampled only in IDLE.
- Empty queue (len_in=0): stays in IDLE, dequeue_out is never asserted, outputs hold at 0.
- Counter widths: the bit counter is $clog2(DATA_WIDTH) bits; the bit timer is max(1,$clog2(BIT_CYCLES)) bits. Neither counter wraps outside its own state.
- dequeue_out is never high for more than one consecutive cycle and never high outside REQ.

Decomposition:
- Package serializer_pkg:
  - state enum ser_state_t {IDLE, REQ, LOAD, SHIFT, GAP}.
  - default constants for DATA_WIDTH and BIT_CYCLES.
- Sub-module bit_tick_gen:
  - BIT_CYCLES counter with clear input and tick output.
  - Reused for the bit timer; the LOAD wait counter is inline.
- FSM, shift register and bit counter live in byte_serializer.

Test Plan:
1. Single word 0xA5, BIT_CYCLES=1: len_in=1, enable_in=1 -> dequeue_out high cycle 1 only; write_out high cycles 3..10; data_out=1,0,1,0,0,1,0,1; done_out high cycle 11.
2. Empty queue: len_in=0, enable_in=1 for 50 cycles -> dequeue_out, write_out and status_out stay 0.
3. Back-to-back: queue model holding 0x3C then 0xFF (len 2->1->0) -> second dequeue_out pulse 12 cycles after the first; bits 00111100 then 11111111; exactly 2 done_out pulses.
4. BIT_CYCLES=4 with word 0x81 -> each bit held 4 cycles; write_out high 32 consecutive cycles; data_out high cycles 3..6 and 31..34, low between.
5. Reset mid-SHIFT: assert reset=0 during the 4th bit -> all outputs 0 within the same cycle (asynchronous); after release, FSM in IDLE and the next word starts cleanly with no extra dequeue.
6. enable_in dropped in cycle 5 of a word -> the word completes with done_out; no REQ while enable_in=0 even with len_in=3.
